instr_mem_ctrl: RTL and testbench

Parametrised, clocked instruction memory for the rv32i core. At run time it is loaded over a byte-stream port, MSB-first per word, instead of by a simulation-only file read. It serves byte-addressed fetches through a valid/ready request/response handshake with one-cycle read latency. Misaligned and out-of-range fetches are flagged as faults. It sits between the PC/fetch stage and the program loader (UART or testbench).

---
 rtl/instr_mem_if.sv | 28 ++
 rtl/instr_mem_ctrl.sv | 123 ++++++++++++
 tb/tb_instr_mem_ctrl.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_mem_if.sv
// instr_mem_if: loader byte stream and fetch request/response bundle for instr_mem_ctrl.
interface instr_mem_if #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 32
);
    localparam int CW = $clog2(DEPTH + 1);
    logic              load_valid;
    logic [7:0]        load_byte;
    logic              load_last;
    logic              load_ready;
    logic [CW-1:0]     loaded_words;
    logic              run;
    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ready;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_instr;
    logic              resp_fault;
    modport master (
        output load_valid, load_byte, load_last, req_valid, req_addr, resp_ready,
        input  load_ready, loaded_words, run, req_ready, resp_valid, resp_instr, resp_fault
    );
    modport slave (
        input  load_valid, load_byte, load_last, req_valid, req_addr, resp_ready,
        output load_ready, loaded_words, run, req_ready, resp_valid, resp_instr, resp_fault
    );
endinterface

// File: rtl/instr_mem_ctrl.sv
// instr_mem_ctrl: byte-stream loaded instruction memory with one-cycle fetch and fault flagging.
// Define IMEM_CLEAR_EN to zero the whole memory after every reset before loading.
module instr_mem_ctrl #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    instr_mem_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [31:0] NOP = 32'h0000_0013;
    typedef enum logic [1:0] {S_CLEAR, S_LOAD, S_RUN} state_t;
`ifdef IMEM_CLEAR_EN
    localparam state_t RST_STATE = S_CLEAR;
`else
    localparam state_t RST_STATE = S_LOAD;
`endif
    state_t            r_state;
    logic [31:0]       r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [CW-1:0]     r_loaded_words;
    logic [1:0]        r_bcnt;
    logic [31:0]       r_shift;
    logic              r_load_ready;
    logic              r_run;
    logic              r_resp_valid;
    logic              r_resp_fault;
    logic [31:0]       r_resp_instr;
    logic              w_load_acc;
    logic              w_word_wr;
    logic              w_mem_we;
    logic [AW-1:0]     w_mem_addr;
    logic [31:0]       w_mem_wdata;
    logic [31:0]       w_word;
    logic              w_req_ready;
    logic              w_req_acc;
    logic              w_fault;
    logic [ADDR_W-1:0] w_word_idx;
`ifdef IMEM_CLEAR_EN
    logic [AW-1:0]     r_clr_ptr;
`endif
    always_comb begin
        w_load_acc  = bus.load_valid & r_load_ready;
        w_word      = r_shift | ({bus.load_byte, 24'h0} >> {r_bcnt, 3'b000});
        w_word_wr   = w_load_acc & ((r_bcnt == 2'd3) | bus.load_last);
`ifdef IMEM_CLEAR_EN
        w_mem_we    = !rst & (w_word_wr | (r_state == S_CLEAR));
        w_mem_addr  = (r_state == S_CLEAR) ? r_clr_ptr : r_wr_ptr;
        w_mem_wdata = (r_state == S_CLEAR) ? 32'h0 : w_word;
`else
        w_mem_we    = !rst & w_word_wr;
        w_mem_addr  = r_wr_ptr;
        w_mem_wdata = w_word;
`endif
        w_req_ready = r_run & (!r_resp_valid | bus.resp_ready);
        w_req_acc   = bus.req_valid & w_req_ready;
        w_word_idx  = bus.req_addr >> 2;
        w_fault     = (bus.req_addr[1:0] != 2'b00) | (w_word_idx >= ADDR_W'(DEPTH));
    end
    // Memory contents survive reset; only CLEAR or the loader overwrite them.
    always_ff @(posedge clk) begin
        if (w_mem_we) r_mem[w_mem_addr] <= w_mem_wdata;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= RST_STATE;
            r_load_ready   <= (RST_STATE == S_LOAD);
            r_run          <= 1'b0;
            r_wr_ptr       <= '0;
            r_loaded_words <= '0;
            r_bcnt         <= 2'd0;
            r_shift        <= 32'h0;
            r_resp_valid   <= 1'b0;
            r_resp_fault   <= 1'b0;
            r_resp_instr   <= 32'h0;
`ifdef IMEM_CLEAR_EN
            r_clr_ptr      <= '0;
`endif
        end else begin
            case (r_state)
`ifdef IMEM_CLEAR_EN
                S_CLEAR: begin
                    r_clr_ptr <= r_clr_ptr + 1'b1;
                    if (r_clr_ptr == AW'(DEPTH - 1)) begin
                        r_state      <= S_LOAD;
                        r_load_ready <= 1'b1;
                    end
                end
`endif
                S_LOAD: if (w_load_acc) begin
                    r_bcnt  <= w_word_wr ? 2'd0 : r_bcnt + 2'd1;
                    r_shift <= w_word_wr ? 32'h0 : w_word;
                    if (w_word_wr) begin
                        r_wr_ptr       <= r_wr_ptr + 1'b1;
                        r_loaded_words <= r_loaded_words + 1'b1;
                        if (bus.load_last | (r_wr_ptr == AW'(DEPTH - 1))) begin
                            r_state      <= S_RUN;
                            r_load_ready <= 1'b0;
                            r_run        <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
            if (w_req_acc) begin
                r_resp_valid <= 1'b1;
                r_resp_fault <= w_fault;
                r_resp_instr <= w_fault ? NOP : r_mem[w_word_idx[AW-1:0]];
            end else if (bus.resp_ready) begin
                r_resp_valid <= 1'b0;
            end
        end
    end
    assign bus.load_ready   = r_load_ready;
    assign bus.loaded_words = r_loaded_words;
    assign bus.run          = r_run;
    assign bus.req_ready    = w_req_ready;
    assign bus.resp_valid   = r_resp_valid;
    assign bus.resp_instr   = r_resp_instr;
    assign bus.resp_fault   = r_resp_fault;
endmodule

// File: tb/tb_instr_mem_ctrl.sv
// tb_instr_mem_ctrl: directed plus randomized checks of instr_mem_ctrl against a word-level model.
module tb_instr_mem_ctrl;
    localparam int DEPTH = 16;
    localparam int ADDR_W = 32;
    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IMEM_CLEAR_EN
    localparam int EXP_WAIT = DEPTH;
`else
    localparam int EXP_WAIT = 0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    logic [31:0] mdl [DEPTH];
    bit known [DEPTH];
    bit m_v;
    bit m_f;
    logic [31:0] m_i;

    instr_mem_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) bus ();
    instr_mem_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.load_valid = 1'b0;
        bus.load_last = 1'b0;
        bus.req_valid = 1'b0;
        bus.resp_ready = 1'b0;
        tick();
        chk("rst_loaded_words", bus.loaded_words, 0);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_resp_fault", bus.resp_fault, 0);
        chk("rst_resp_instr", bus.resp_instr, 0);
        chk("rst_run", bus.run, 0);
        rst = 1'b0;
    endtask

    task automatic wait_load_ready();
        int n = 0;
        while (!bus.load_ready && n < 200) begin
            tick();
            n++;
        end
        chk("load_ready_delay", n, EXP_WAIT);
`ifdef IMEM_CLEAR_EN
        for (int i = 0; i < DEPTH; i++) begin
            mdl[i] = 32'h0;
            known[i] = 1'b1;
        end
`endif
    endtask

    task automatic send_byte(input logic [7:0] b, input bit last);
        bus.load_valid = 1'b1;
        bus.load_byte = b;
        bus.load_last = last;
        #1;
        chk("load_ready_during_load", bus.load_ready, 1);
        tick();
        bus.load_valid = 1'b0;
        bus.load_last = 1'b0;
    endtask

    task automatic load_prog(input logic [7:0] b[$], input bit use_last);
        int nw;
        logic [31:0] x;
        nw = (b.size() + 3) / 4;
        for (int i = 0; i < b.size(); i++) send_byte(b[i], use_last && (i == b.size() - 1));
        for (int w = 0; w < nw; w++) begin
            x = 32'h0;
            for (int j = 0; j < 4; j++) if (4 * w + j < b.size()) x[31 - 8 * j -: 8] = b[4 * w + j];
            mdl[w] = x;
            known[w] = 1'b1;
        end
        chk("loaded_words", bus.loaded_words, nw);
        chk("run_after_load", bus.run, 1);
        chk("req_ready_after_load", bus.req_ready, 1);
    endtask

    task automatic expect_resp(input logic [31:0] a, output bit f, output logic [31:0] i);
        logic [31:0] idx;
        idx = a / 4;
        f = (a % 4 != 0) || (idx >= DEPTH);
        i = f ? NOP : mdl[idx];
    endtask

    task automatic fetch1(input string tag, input logic [31:0] a, input logic [31:0] exp_i, input bit exp_f);
        bus.req_valid = 1'b1;
        bus.req_addr = a;
        bus.resp_ready = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        chk({tag, "_valid"}, bus.resp_valid, 1);
        chk({tag, "_instr"}, bus.resp_instr, exp_i);
        chk({tag, "_fault"}, bus.resp_fault, exp_f);
        tick();
        chk({tag, "_drain"}, bus.resp_valid, 0);
    endtask

    function automatic logic [31:0] pick_addr();
        int idx;
        int low;
        if ($urandom_range(0, 9) == 0) return 32'hFFFF_FFF0;
        idx = $urandom_range(0, DEPTH + 3);
        if (idx < DEPTH && !known[idx]) idx = 0;
        low = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
        return 32'(idx * 4 + low);
    endfunction

    task automatic rand_fetch(input int n);
        bit rv;
        bit rr;
        logic [31:0] a;
        m_v = 1'b0;
        for (int c = 0; c < n; c++) begin
            rv = 1'($urandom_range(0, 1));
            rr = ($urandom_range(0, 3) != 0);
            a = pick_addr();
            bus.req_valid = rv;
            bus.req_addr = a;
            bus.resp_ready = rr;
            #1;
            chk("rnd_req_ready", bus.req_ready, !m_v || rr);
            tick();
            if (rv && (!m_v || rr)) begin
                m_v = 1'b1;
                expect_resp(a, m_f, m_i);
            end else if (rr) begin
                m_v = 1'b0;
            end
            chk("rnd_resp_valid", bus.resp_valid, m_v);
            if (m_v) begin
                chk("rnd_resp_instr", bus.resp_instr, m_i);
                chk("rnd_resp_fault", bus.resp_fault, m_f);
            end
        end
        bus.req_valid = 1'b0;
        bus.resp_ready = 1'b1;
        tick();
        chk("rnd_drain", bus.resp_valid, 0);
    endtask

    initial begin
        logic [7:0] prog[$];
        bus.load_valid = 1'b0;
        bus.load_byte = 8'h0;
        bus.load_last = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_addr = '0;
        bus.resp_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
        tick();
        do_reset();
        wait_load_ready();
        prog = '{8'h00, 8'h93, 8'h00, 8'h50, 8'h01, 8'h13};
        load_prog(prog, 1'b1);
        fetch1("fetch_4", 32'h4, 32'h0113_0000, 1'b0);
        fetch1("fetch_0", 32'h0, 32'h0093_0050, 1'b0);
        fetch1("fetch_misaligned", 32'h2, NOP, 1'b1);
        fetch1("fetch_oob", 32'h40, NOP, 1'b1);
        // back-to-back fetches
        bus.req_valid = 1'b1;
        bus.req_addr = 32'h0;
        bus.resp_ready = 1'b1;
        tick();
        chk("b2b_first", bus.resp_instr, 32'h0093_0050);
        bus.req_addr = 32'h4;
        tick();
        chk("b2b_second_valid", bus.resp_valid, 1);
        chk("b2b_second", bus.resp_instr, 32'h0113_0000);
        bus.req_valid = 1'b0;
        tick();
        chk("b2b_drain", bus.resp_valid, 0);
        // stalled consumer holds the response and blocks new requests
        bus.req_valid = 1'b1;
        bus.req_addr = 32'h0;
        bus.resp_ready = 1'b0;
        tick();
        chk("hold_first", bus.resp_instr, 32'h0093_0050);
        bus.req_addr = 32'h4;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("hold_req_ready", bus.req_ready, 0);
            tick();
            chk("hold_valid", bus.resp_valid, 1);
            chk("hold_instr", bus.resp_instr, 32'h0093_0050);
            chk("hold_fault", bus.resp_fault, 0);
        end
        bus.resp_ready = 1'b1;
        #1;
        chk("release_req_ready", bus.req_ready, 1);
        tick();
        chk("release_valid", bus.resp_valid, 1);
        chk("release_instr", bus.resp_instr, 32'h0113_0000);
        bus.req_valid = 1'b0;
        tick();
        chk("release_drain", bus.resp_valid, 0);
        rand_fetch(40);
        // leave a response outstanding, then reset
        bus.req_valid = 1'b1;
        bus.req_addr = 32'h0;
        bus.resp_ready = 1'b0;
        tick();
        chk("pre_reset_valid", bus.resp_valid, 1);
        do_reset();
        wait_load_ready();
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        do_reset();
        wait_load_ready();
        prog.delete();
        for (int i = 0; i < DEPTH * 4; i++) prog.push_back(8'($urandom_range(0, 255)));
        load_prog(prog, 1'b0);
        bus.load_valid = 1'b1;
        bus.load_byte = 8'h5A;
        tick();
        bus.load_valid = 1'b0;
        chk("ignored_byte_count", bus.loaded_words, DEPTH);
        chk("ignored_byte_ready", bus.load_ready, 0);
        fetch1("full_first", 32'h0, mdl[0], 1'b0);
        fetch1("full_last", 32'h3C, mdl[DEPTH - 1], 1'b0);
        rand_fetch(40);
        do_reset();
        wait_load_ready();
        prog.delete();
        for (int i = 0; i < int'($urandom_range(1, 4)); i++) prog.push_back(8'($urandom_range(0, 255)));
        load_prog(prog, 1'b1);
        fetch1("short_word0", 32'h0, mdl[0], 1'b0);
        fetch1("short_tail", 32'h3C, mdl[DEPTH - 1], 1'b0);
`ifdef IMEM_CLEAR_EN
        fetch1("cleared_tail", 32'h3C, 32'h0, 1'b0);
`endif
        rand_fetch(40);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
